// File: rtl/pattern_sequencer_pkg.sv
// pattern_sequencer_pkg
//   Shared definitions for the pattern playback engine: default widths and
//   the sequencer state encoding. The encoding is exported on seq_state, so
//   status/readback logic elsewhere imports this package to decode it.
//   Ports: none (package).
package pattern_sequencer_pkg;

  localparam int SEQ_ADDR_W  = 8;
  localparam int SEQ_DATA_W  = 16;
  localparam int SEQ_DWELL_W = 32;
  localparam int SEQ_STATE_W = 3;

  // Encoding values are visible to software through seq_state; keep them fixed.
  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DWELL     = 3'd5,
    ST_NEXT      = 3'd6
  } seq_state_t;

endpackage

// File: rtl/pattern_sequencer_dwell_timer.sv
// pattern_sequencer_dwell_timer (the dwell_timer of pattern_sequencer)
//   Counts hold cycles after each actuator update. load clears the count,
//   enable advances it, and expired is asserted in the enabled cycle whose
//   count equals terminal_count, so an enabled window lasts
//   terminal_count+1 cycles.
//   Ports:
//     clock          system clock (rising edge)
//     reset_n        synchronous active-low reset
//     load           clear the counter for a new hold window
//     enable         advance the counter this cycle
//     terminal_count last count value of the window
//     expired        high in the final cycle of the window
module pattern_sequencer_dwell_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal_count,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  // Decoded from registered count and registered terminal only, so the
  // sequencer's next-state logic sees no path from primary inputs here.
  assign expired = enable && (count_q == terminal_count);

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//   Autonomous playback engine for the actuator pattern memory. A start
//   strobe latches a start/end address and dwell time; each word in the
//   (wrapping) address range is read, presented to the actuator driver,
//   acknowledged by update_done and then held for the dwell time.
//   Optional build macro: PATTERN_SEQUENCER_LOOP_EN adds loop_n; when it is
//   latched low the sequence repeats from start_address until stop_n.
//   Ports:
//     clock, reset_n             clock and synchronous active-low reset
//     start_n, stop_n            active-low start strobe / abort
//     loop_n                     (LOOP_EN builds only) active-low repeat
//     start_address, end_address sequence bounds, latched at start
//     dwell_count                hold cycles after update_done, latched at start
//     memory_data_in             read data, valid the cycle after the read strobe
//     memory_enable_n/read_n     active-low memory strobes
//     memory_address             current word address
//     actuator_data              registered word for the actuator driver
//     actuator_load_n            one-cycle active-low load strobe
//     update_done                driver finished applying actuator_data
//     busy_n, done_n             status: not idle / sequence complete pulse
//     seq_state                  current state encoding
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int ADDR_W  = SEQ_ADDR_W,
  parameter int DATA_W  = SEQ_DATA_W,
  parameter int DWELL_W = SEQ_DWELL_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start_n,
  input  logic                   stop_n,
`ifdef PATTERN_SEQUENCER_LOOP_EN
  input  logic                   loop_n,
`endif
  input  logic [ADDR_W-1:0]      start_address,
  input  logic [ADDR_W-1:0]      end_address,
  input  logic [DWELL_W-1:0]     dwell_count,
  input  logic [DATA_W-1:0]      memory_data_in,
  output logic                   memory_enable_n,
  output logic                   memory_read_n,
  output logic [ADDR_W-1:0]      memory_address,
  output logic [DATA_W-1:0]      actuator_data,
  output logic                   actuator_load_n,
  input  logic                   update_done,
  output logic                   busy_n,
  output logic                   done_n,
  output logic [SEQ_STATE_W-1:0] seq_state
);

  seq_state_t         state;
  seq_state_t         state_next;
  logic [ADDR_W-1:0]  address_q;
  logic [ADDR_W-1:0]  start_q;
  logic [ADDR_W-1:0]  end_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               at_end;
  logic               restart_loop;
  logic               starting;
  logic               timer_load;
  logic               timer_expired;

  assign at_end   = (address_q == end_q);
  assign starting = (state == ST_IDLE) && (state_next == ST_READ);

`ifdef PATTERN_SEQUENCER_LOOP_EN
  logic loop_q;

  // Loop mode is captured with the rest of the configuration at start.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      loop_q <= 1'b0;
    end else if (starting) begin
      loop_q <= !loop_n;
    end
  end

  assign restart_loop = loop_q;
`else
  assign restart_loop = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. An abort overrides everything outside IDLE; in IDLE a
  // simultaneous stop suppresses the start.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    if ((state != ST_IDLE) && !stop_n) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!start_n && stop_n) begin
            state_next = ST_READ;
          end
        end
        ST_READ:    state_next = ST_CAPTURE;
        ST_CAPTURE: state_next = ST_LOAD;
        ST_LOAD:    state_next = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (update_done) begin
            if (dwell_q == '0) begin
              state_next = ST_NEXT;
            end else begin
              state_next = ST_DWELL;
              timer_load = 1'b1;
            end
          end
        end
        ST_DWELL: begin
          if (timer_expired) begin
            state_next = ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (at_end && !restart_loop) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_READ;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: configuration latch, address stepping and actuator word.
  // Qualifying on state_next keeps an aborted CAPTURE from overwriting the
  // word the actuator currently holds.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      address_q     <= '0;
      start_q       <= '0;
      end_q         <= '0;
      dwell_q       <= '0;
      actuator_data <= '0;
    end else begin
      if (starting) begin
        start_q   <= start_address;
        end_q     <= end_address;
        dwell_q   <= dwell_count;
        address_q <= start_address;
      end
      if ((state == ST_CAPTURE) && (state_next == ST_LOAD)) begin
        actuator_data <= memory_data_in;
      end
      if ((state == ST_NEXT) && (state_next == ST_READ)) begin
        address_q <= at_end ? start_q : address_q + ADDR_W'(1);
      end
    end
  end

  // The dwell window is dwell_q cycles long, hence terminal count dwell_q-1.
  pattern_sequencer_dwell_timer #(
    .WIDTH(DWELL_W)
  ) u_dwell_timer (
    .clock         (clock),
    .reset_n       (reset_n),
    .load          (timer_load),
    .enable        (state == ST_DWELL),
    .terminal_count(dwell_q - DWELL_W'(1)),
    .expired       (timer_expired)
  );

  assign memory_address  = address_q;
  assign memory_enable_n = (state != ST_READ);
  assign memory_read_n   = (state != ST_READ);
  assign actuator_load_n = (state != ST_LOAD);
  assign busy_n          = (state == ST_IDLE);
  assign done_n          = !((state == ST_NEXT) && at_end && !restart_loop);
  assign seq_state       = state;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer
//   Scoreboard bench for pattern_sequencer. Each started sequence pushes the
//   expected read addresses, actuator words and completion pulse into
//   queues; a monitor pops and compares whenever the DUT strobes. A memory
//   model and an actuator driver model (update_done two cycles after each
//   load) run alongside.
module tb_pattern_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start_n;
  logic        stop_n;
  logic [7:0]  start_address;
  logic [7:0]  end_address;
  logic [31:0] dwell_count;
  logic [15:0] memory_data_in;
  logic        memory_enable_n;
  logic        memory_read_n;
  logic [7:0]  memory_address;
  logic [15:0] actuator_data;
  logic        actuator_load_n;
  logic        update_done;
  logic        busy_n;
  logic        done_n;
  logic [2:0]  seq_state;
`ifdef PATTERN_SEQUENCER_LOOP_EN
  logic        loop_n;
`endif

  logic        drv_done;
  logic        stray_done;
  int          drv_cnt;
  logic [15:0] mem [256];

  logic [7:0]  exp_read_q [$];
  logic [15:0] exp_load_q [$];
  int          exp_done;
  int          cur_dwell;
  int          loads_seen;
  logic        gap_armed;
  int          done_cycle;
  int          cycle;
  int          checks_total;
  int          checks_passed;

  pattern_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start_n        (start_n),
    .stop_n         (stop_n),
`ifdef PATTERN_SEQUENCER_LOOP_EN
    .loop_n         (loop_n),
`endif
    .start_address  (start_address),
    .end_address    (end_address),
    .dwell_count    (dwell_count),
    .memory_data_in (memory_data_in),
    .memory_enable_n(memory_enable_n),
    .memory_read_n  (memory_read_n),
    .memory_address (memory_address),
    .actuator_data  (actuator_data),
    .actuator_load_n(actuator_load_n),
    .update_done    (update_done),
    .busy_n         (busy_n),
    .done_n         (done_n),
    .seq_state      (seq_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign update_done = drv_done | stray_done;

  always @(posedge clock) cycle <= cycle + 1;

  // Synchronous-read memory: data appears the cycle after the read strobe.
  always @(posedge clock) begin
    if (!memory_enable_n && !memory_read_n) memory_data_in <= mem[memory_address];
  end

  // Actuator driver: acknowledges each load two cycles later.
  initial begin
    drv_done = 1'b0;
    drv_cnt  = 0;
    forever begin
      @(posedge clock);
      #2;
      drv_done = 1'b0;
      if (drv_cnt > 0) begin
        drv_cnt--;
        if (drv_cnt == 0) drv_done = 1'b1;
      end
      if (!actuator_load_n) drv_cnt = 2;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
  endtask

  // Monitor: compares every strobe against the scoreboard queues.
  initial begin
    logic [7:0] a;
    logic [15:0] d;
    gap_armed = 1'b0;
    done_cycle = 0;
    loads_seen = 0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (!memory_read_n) begin
          checkOutput("read_expected", 32'(exp_read_q.size() != 0), 1);
          checkOutput("read_enable", 32'(memory_enable_n), 0);
          if (exp_read_q.size() != 0) begin
            a = exp_read_q.pop_front();
            checkOutput("read_address", 32'(memory_address), 32'(a));
          end
          if (gap_armed) begin
            checkOutput("dwell_gap", 32'(cycle - done_cycle), 32'(cur_dwell + 2));
            gap_armed = 1'b0;
          end
        end
        if (!actuator_load_n) begin
          loads_seen++;
          checkOutput("load_expected", 32'(exp_load_q.size() != 0), 1);
          if (exp_load_q.size() != 0) begin
            d = exp_load_q.pop_front();
            checkOutput("load_data", 32'(actuator_data), 32'(d));
          end
        end
        if (!done_n) begin
          checkOutput("done_expected", 32'(exp_done > 0), 1);
          if (exp_done > 0) exp_done--;
        end
        if (busy_n) gap_armed = 1'b0;
        else if (drv_done) begin
          gap_armed  = 1'b1;
          done_cycle = cycle;
        end
      end
    end
  end

  // One-cycle strobe of start/stop with a configuration; the configuration
  // is scrambled afterwards since the DUT must have latched it already.
  task automatic applyStimulus(input logic st_n, input logic sp_n, input logic [7:0] sa,
                               input logic [7:0] ea, input logic [31:0] dw);
    @(posedge clock); #1;
    start_n = st_n; stop_n = sp_n;
    start_address = sa; end_address = ea; dwell_count = dw;
    @(posedge clock); #1;
    start_n = 1'b1; stop_n = 1'b1;
    start_address = 8'($urandom); end_address = 8'($urandom);
    dwell_count = 32'($urandom_range(0, 9));
  endtask

  task automatic waitIdle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock); #1;
      if (busy_n && exp_read_q.size() == 0 && exp_load_q.size() == 0 && exp_done == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({name, "_complete"}, 32'(ok), 1);
    checkOutput({name, "_busy_n"}, 32'(busy_n), 1);
  endtask

  // Reference model: words s, s+1, ... e (mod 256), then one done pulse.
  task automatic runSequence(input string name, input logic [7:0] s, input logic [7:0] e,
                             input int d, input logic extra);
    int n;
    logic [7:0] a;
    n = int'(8'(e - s)) + 1;
    for (int i = 0; i < n; i++) begin
      a = 8'(int'(s) + i);
      exp_read_q.push_back(a);
      exp_load_q.push_back(mem[a]);
    end
    exp_done++;
    cur_dwell = d;
    applyStimulus(1'b0, 1'b1, s, e, 32'(d));
    if (extra) begin
      repeat (3) @(posedge clock);
      applyStimulus(1'b0, 1'b1, 8'(s + 8'd40), 8'(e + 8'd41), 32'd0);
    end
    waitIdle(name);
  endtask

  task automatic waitLoad(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #1;
      if (!actuator_load_n) begin ok = 1'b1; break; end
    end
    checkOutput({name, "_load_seen"}, 32'(ok), 1);
  endtask

  task automatic flushScoreboard();
    exp_read_q.delete();
    exp_load_q.delete();
    exp_done = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ok;
    int len;
    logic [7:0] s;
    checks_total = 0; checks_passed = 0; exp_done = 0; cur_dwell = 0;
    reset_n = 1'b0; start_n = 1'b1; stop_n = 1'b1; stray_done = 1'b0;
    start_address = '0; end_address = '0; dwell_count = '0;
`ifdef PATTERN_SEQUENCER_LOOP_EN
    loop_n = 1'b1;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'(16'hA000 + i);

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_busy_n", 32'(busy_n), 1);
    checkOutput("reset_done_n", 32'(done_n), 1);
    checkOutput("reset_read_n", 32'(memory_read_n), 1);
    checkOutput("reset_enable_n", 32'(memory_enable_n), 1);
    checkOutput("reset_load_n", 32'(actuator_load_n), 1);
    checkOutput("reset_address", 32'(memory_address), 0);
    checkOutput("reset_actuator", 32'(actuator_data), 0);
    checkOutput("reset_state", 32'(seq_state), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    $display("[TB] basic sequence 0x10..0x12, dwell 0");
    runSequence("basic", 8'h10, 8'h12, 0, 1'b0);
    checkOutput("basic_last_word", 32'(actuator_data), 32'h0000A012);

    $display("[TB] wrap sequence 0xFE..0x01, dwell 3");
    runSequence("wrap", 8'hFE, 8'h01, 3, 1'b0);

    $display("[TB] single word with ignored extra start");
    runSequence("single", 8'h33, 8'h33, 2, 1'b0);
    runSequence("extra_start", 8'h50, 8'h53, 1, 1'b1);

    $display("[TB] stop during dwell");
    exp_read_q.push_back(8'h20);
    exp_load_q.push_back(mem[8'h20]);
    cur_dwell = 6;
    applyStimulus(1'b0, 1'b1, 8'h20, 8'h28, 32'd6);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #1;
      if (drv_done) begin ok = 1'b1; break; end
    end
    checkOutput("stop_update_seen", 32'(ok), 1);
    @(posedge clock); #1; stop_n = 1'b0;
    @(posedge clock); #1; stop_n = 1'b1;
    @(negedge clock); #1;
    checkOutput("stop_busy_n", 32'(busy_n), 1);
    checkOutput("stop_state", 32'(seq_state), 0);
    checkOutput("stop_actuator_kept", 32'(actuator_data), 32'(mem[8'h20]));
    repeat (5) @(negedge clock);
    checkOutput("stop_no_more_reads", 32'(exp_read_q.size()), 0);
    runSequence("restart", 8'h30, 8'h31, 1, 1'b0);

    $display("[TB] start with stop, stray update_done");
    applyStimulus(1'b0, 1'b0, 8'h44, 8'h45, 32'd0);
    repeat (3) begin
      @(negedge clock); #1;
      checkOutput("start_stop_idle", 32'(busy_n), 1);
    end
    @(posedge clock); #1; stray_done = 1'b1;
    @(posedge clock); #1; stray_done = 1'b0;
    @(negedge clock); #1;
    checkOutput("stray_idle", 32'(busy_n), 1);
    checkOutput("stray_no_load", 32'(actuator_load_n), 1);

    $display("[TB] reset during WAIT_DONE");
    exp_read_q.push_back(8'h40); exp_read_q.push_back(8'h41);
    exp_load_q.push_back(mem[8'h40]); exp_load_q.push_back(mem[8'h41]);
    exp_done = 1;
    cur_dwell = 1;
    applyStimulus(1'b0, 1'b1, 8'h40, 8'h41, 32'd1);
    waitLoad("reset_run");
    @(posedge clock); #1; reset_n = 1'b0;
    @(posedge clock); #1; reset_n = 1'b1;
    flushScoreboard();
    @(negedge clock); #1;
    checkOutput("rst2_busy_n", 32'(busy_n), 1);
    checkOutput("rst2_load_n", 32'(actuator_load_n), 1);
    checkOutput("rst2_read_n", 32'(memory_read_n), 1);
    checkOutput("rst2_address", 32'(memory_address), 0);
    checkOutput("rst2_actuator", 32'(actuator_data), 0);
    repeat (4) @(negedge clock);

`ifdef PATTERN_SEQUENCER_LOOP_EN
    $display("[TB] loop mode on word 0x05");
    for (int i = 0; i < 60; i++) begin
      exp_read_q.push_back(8'h05);
      exp_load_q.push_back(mem[8'h05]);
    end
    cur_dwell = 0;
    loop_n = 1'b0;
    loads_seen = 0;
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h05, 32'd0);
    loop_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (loads_seen >= 4) begin ok = 1'b1; break; end
    end
    checkOutput("loop_repeats", 32'(ok), 1);
    @(posedge clock); #1; stop_n = 1'b0;
    @(posedge clock); #1; stop_n = 1'b1;
    flushScoreboard();
    @(negedge clock); #1;
    checkOutput("loop_stopped", 32'(busy_n), 1);
`endif

    $display("[TB] randomized sequences");
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int r = 0; r < 8; r++) begin
      s   = 8'($urandom_range(0, 255));
      len = int'($urandom_range(1, 5));
      runSequence("random", s, 8'(int'(s) + len - 1), int'($urandom_range(0, 4)), 1'b0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
